riscv_core_muldiv_ctrl: RTL and testbench

RISCV_CORE_MULDIV_CTRL -- requirements
Module: riscv_core_muldiv_ctrl

---
 rtl/riscv_core_muldiv_ctrl.sv | 105 ++++++++++
 tb/tb_riscv_core_muldiv_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_muldiv_ctrl.sv
// Sequencing FSM for the RISC-V M-extension unit: accepts an op from EX, runs the
// multiplier pipeline or the iterative divider, and presents a one-cycle result strobe.
module riscv_core_muldiv_ctrl #(
  parameter int MUL_LATENCY = 4,
  parameter int XLEN        = 64
) (
  input  logic       i_muldiv_ctrl_clk,
  input  logic       i_muldiv_ctrl_rst,
  input  logic       i_muldiv_ctrl_start_ex,
  input  logic [2:0] i_muldiv_ctrl_funct3_ex,
  input  logic       i_muldiv_ctrl_word_ex,
  input  logic       i_muldiv_ctrl_div_zero_ex,
  input  logic       i_muldiv_ctrl_div_ovf_ex,
  input  logic       i_muldiv_ctrl_flush,
  output logic       o_muldiv_ctrl_stall,
  output logic       o_muldiv_ctrl_load,
  output logic       o_muldiv_ctrl_mul_en,
  output logic       o_muldiv_ctrl_div_step,
  output logic       o_muldiv_ctrl_special,
  output logic [2:0] o_muldiv_ctrl_funct3_q,
  output logic       o_muldiv_ctrl_word_q,
  output logic       o_muldiv_ctrl_result_valid,
  output logic       o_muldiv_ctrl_busy
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [5:0] MUL_INIT  = 6'(MUL_LATENCY - 1);
  localparam logic [5:0] DIV_INIT  = 6'(XLEN - 1);
  localparam logic [5:0] DIVW_INIT = 6'(XLEN / 2 - 1);

  state_t     state_q, state_d;
  logic [5:0] count_q, count_d;
  logic       is_div;
  logic       special_d;

  assign is_div    = i_muldiv_ctrl_funct3_ex[2];
  assign special_d = is_div & (i_muldiv_ctrl_div_zero_ex | i_muldiv_ctrl_div_ovf_ex);
  assign o_muldiv_ctrl_busy = (state_q != IDLE);

  // Flush always wins over counter expiry, and stall drops in the flush cycle itself.
  always_comb begin
    state_d                    = state_q;
    count_d                    = count_q;
    o_muldiv_ctrl_stall        = 1'b0;
    o_muldiv_ctrl_load         = 1'b0;
    o_muldiv_ctrl_mul_en       = 1'b0;
    o_muldiv_ctrl_div_step     = 1'b0;
    o_muldiv_ctrl_result_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_muldiv_ctrl_start_ex && !i_muldiv_ctrl_flush) begin
          o_muldiv_ctrl_load  = 1'b1;
          o_muldiv_ctrl_stall = 1'b1;
          if (!is_div) begin
            state_d = MUL;
            count_d = MUL_INIT;
          end else if (special_d) begin
            state_d = DONE;
          end else begin
            state_d = DIV;
            count_d = i_muldiv_ctrl_word_ex ? DIVW_INIT : DIV_INIT;
          end
        end
      end
      MUL, DIV: begin
        o_muldiv_ctrl_mul_en   = (state_q == MUL);
        o_muldiv_ctrl_div_step = (state_q == DIV);
        o_muldiv_ctrl_stall    = !i_muldiv_ctrl_flush;
        if (i_muldiv_ctrl_flush) begin
          state_d = IDLE;
        end else if (count_q == 6'd0) begin
          state_d = DONE;
        end else begin
          count_d = count_q - 6'd1;
        end
      end
      DONE: begin
        o_muldiv_ctrl_result_valid = !i_muldiv_ctrl_flush;
        state_d                    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The op descriptor is latched only on the accept cycle and held until the next accept.
  always_ff @(posedge i_muldiv_ctrl_clk or posedge i_muldiv_ctrl_rst) begin
    if (i_muldiv_ctrl_rst) begin
      state_q                <= IDLE;
      count_q                <= 6'd0;
      o_muldiv_ctrl_special  <= 1'b0;
      o_muldiv_ctrl_funct3_q <= 3'd0;
      o_muldiv_ctrl_word_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (o_muldiv_ctrl_load) begin
        o_muldiv_ctrl_special  <= special_d;
        o_muldiv_ctrl_funct3_q <= i_muldiv_ctrl_funct3_ex;
        o_muldiv_ctrl_word_q   <= i_muldiv_ctrl_word_ex;
      end
    end
  end

endmodule

// File: tb/tb_riscv_core_muldiv_ctrl.sv
// Testbench for riscv_core_muldiv_ctrl: a latency-based transaction model checks every
// cycle, while directed scenarios pin exact cycle counts with literal expectations.
module tb_riscv_core_muldiv_ctrl;

  localparam int MUL_LAT = 4;
  localparam int XLEN    = 64;

  logic       clk = 1'b0;
  logic       rst, start, word, dz, ovf, flush;
  logic [2:0] f3;
  logic       stall, load, mul_en, div_step, special, word_q, result_valid, busy;
  logic [2:0] funct3_q;

  int n_checks = 0;
  int n_fail   = 0;

  riscv_core_muldiv_ctrl #(.MUL_LATENCY(MUL_LAT), .XLEN(XLEN)) dut (
    .i_muldiv_ctrl_clk          (clk),
    .i_muldiv_ctrl_rst          (rst),
    .i_muldiv_ctrl_start_ex     (start),
    .i_muldiv_ctrl_funct3_ex    (f3),
    .i_muldiv_ctrl_word_ex      (word),
    .i_muldiv_ctrl_div_zero_ex  (dz),
    .i_muldiv_ctrl_div_ovf_ex   (ovf),
    .i_muldiv_ctrl_flush        (flush),
    .o_muldiv_ctrl_stall        (stall),
    .o_muldiv_ctrl_load         (load),
    .o_muldiv_ctrl_mul_en       (mul_en),
    .o_muldiv_ctrl_div_step     (div_step),
    .o_muldiv_ctrl_special      (special),
    .o_muldiv_ctrl_funct3_q     (funct3_q),
    .o_muldiv_ctrl_word_q       (word_q),
    .o_muldiv_ctrl_result_valid (result_valid),
    .o_muldiv_ctrl_busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  // Inputs change just after the rising edge so the falling-edge samples see them settled.
  task automatic applyStimulus(input logic r, input logic s, input logic [2:0] op,
                               input logic w, input logic z, input logic o, input logic fl);
    @(posedge clk);
    #1;
    rst = r; start = s; f3 = op; word = w; dz = z; ovf = o; flush = fl;
  endtask

  // Reference model: an accepted op is described only by the cycle its result is due.
  int       cyc;
  bit       m_active;
  int       m_done_at;
  bit       m_is_mul;
  bit       m_special;
  bit [2:0] m_f3;
  bit       m_w;
  bit       e_load, e_stall, e_mul, e_div, e_rv, e_busy;
  int       lat;

  initial begin
    cyc = 0; m_active = 0; m_done_at = 0; m_is_mul = 0;
    m_special = 0; m_f3 = 0; m_w = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_active = 0; m_special = 0; m_f3 = 0; m_w = 0;
        e_load = 0; e_stall = 0; e_mul = 0; e_div = 0; e_rv = 0; e_busy = 0;
      end else begin
        e_load = 0; e_stall = 0; e_mul = 0; e_div = 0; e_rv = 0; e_busy = 0;
        if (!m_active) begin
          e_load  = start && !flush;
          e_stall = e_load;
        end else if (cyc < m_done_at) begin
          e_busy  = 1;
          e_mul   = m_is_mul;
          e_div   = !m_is_mul;
          e_stall = !flush;
        end else begin
          e_busy = 1;
          e_rv   = !flush;
        end
      end
      checkOutput("load", load, e_load);
      checkOutput("stall", stall, e_stall);
      checkOutput("mul_en", mul_en, e_mul);
      checkOutput("div_step", div_step, e_div);
      checkOutput("result_valid", result_valid, e_rv);
      checkOutput("busy", busy, e_busy);
      checkOutput("special", special, m_special);
      checkOutput("funct3_q", funct3_q, m_f3);
      checkOutput("word_q", word_q, m_w);
      checkOutput("exclusive", int'(load) + int'(mul_en) + int'(div_step) <= 1, 1);
      if (!rst) begin
        if (!m_active && e_load) begin
          m_active  = 1;
          m_is_mul  = !f3[2];
          m_special = f3[2] && (dz || ovf);
          m_f3      = f3;
          m_w       = word;
          if (m_is_mul)       lat = MUL_LAT + 1;
          else if (m_special) lat = 1;
          else if (word)      lat = XLEN / 2 + 1;
          else                lat = XLEN + 1;
          m_done_at = cyc + lat;
        end else if (m_active && (cyc == m_done_at || flush)) begin
          m_active = 0;
        end
      end
      cyc++;
    end
  end

  // Issue one op and count cycles until its result strobe (or -1 if it never comes).
  task automatic runOp(input logic [2:0] op, input logic w, input logic z, input logic o,
                       output int rv_lat, output int n_mul, output int n_div);
    rv_lat = -1; n_mul = 0; n_div = 0;
    applyStimulus(0, 1, op, w, z, o, 0);
    @(negedge clk);
    for (int k = 1; k < 200 && rv_lat < 0; k++) begin
      applyStimulus(0, 0, 3'd0, 0, 0, 0, 0);
      @(negedge clk);
      n_mul += int'(mul_en);
      n_div += int'(div_step);
      if (result_valid) rv_lat = k;
    end
  endtask

  task automatic drainIdle();
    bit idle_seen;
    idle_seen = 0;
    for (int k = 0; k < 200 && !idle_seen; k++) begin
      applyStimulus(0, 0, 3'd0, 0, 0, 0, 0);
      @(negedge clk);
      idle_seen = !busy;
    end
    checkOutput("drain_idle", idle_seen, 1);
  endtask

  initial begin
    int l, nm, nd, r_at, l2_at, rvs;
    rst = 1; start = 0; f3 = 0; word = 0; dz = 0; ovf = 0; flush = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_funct3_q", funct3_q, 0);
    applyStimulus(0, 0, 3'd0, 0, 0, 0, 0);

    runOp(3'b000, 0, 0, 0, l, nm, nd);
    checkOutput("mul_latency", l, 5);
    checkOutput("mul_en_cycles", nm, 4);
    checkOutput("mul_div_steps", nd, 0);

    runOp(3'b100, 0, 0, 0, l, nm, nd);
    checkOutput("div64_latency", l, 65);
    checkOutput("div64_steps", nd, 64);

    runOp(3'b100, 1, 0, 0, l, nm, nd);
    checkOutput("divw_latency", l, 33);
    checkOutput("divw_steps", nd, 32);
    checkOutput("divw_word_q", word_q, 1);

    runOp(3'b101, 0, 1, 0, l, nm, nd);
    checkOutput("divz_latency", l, 1);
    checkOutput("divz_steps", nd, 0);
    checkOutput("divz_special", special, 1);
    checkOutput("divz_funct3_q", funct3_q, 5);

    runOp(3'b110, 0, 0, 1, l, nm, nd);
    checkOutput("ovf_latency", l, 1);

    // Flush in the 10th divide cycle.
    applyStimulus(0, 1, 3'b100, 0, 0, 0, 0);
    @(negedge clk);
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(0, 0, 3'd0, 0, 0, 0, 0);
      @(negedge clk);
    end
    applyStimulus(0, 0, 3'd0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("flush_stall", stall, 0);
    applyStimulus(0, 0, 3'd0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("flush_idle", busy, 0);
    rvs = 0;
    repeat (70) begin
      applyStimulus(0, 0, 3'd0, 0, 0, 0, 0);
      @(negedge clk);
      rvs += int'(result_valid);
    end
    checkOutput("flush_no_result", rvs, 0);
    runOp(3'b000, 0, 0, 0, l, nm, nd);
    checkOutput("post_flush_mul", l, 5);

    // Back-to-back multiplies with start held high.
    applyStimulus(0, 1, 3'b000, 0, 0, 0, 0);
    @(negedge clk);
    r_at = -1; l2_at = -1;
    for (int k = 1; k <= 20 && l2_at < 0; k++) begin
      applyStimulus(0, 1, 3'b000, 0, 0, 0, 0);
      @(negedge clk);
      if (result_valid && r_at < 0) r_at = k;
      if (load) l2_at = k;
    end
    checkOutput("b2b_first_result", r_at, 5);
    checkOutput("b2b_second_load", l2_at, 6);
    drainIdle();

    // Reset while the divider counter reads 20.
    applyStimulus(0, 1, 3'b100, 0, 0, 0, 0);
    @(negedge clk);
    for (int k = 1; k <= 43; k++) begin
      applyStimulus(0, 0, 3'd0, 0, 0, 0, 0);
      @(negedge clk);
    end
    applyStimulus(1, 0, 3'd0, 0, 0, 0, 0);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_stall", stall, 0);
    rvs = 0;
    repeat (80) begin
      applyStimulus(0, 0, 3'd0, 0, 0, 0, 0);
      @(negedge clk);
      rvs += int'(result_valid);
    end
    checkOutput("rst_no_result", rvs, 0);

    // Randomized traffic, checked cycle by cycle by the model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 399) == 0)
        applyStimulus(1, 0, 3'd0, 0, 0, 0, 0);
      else
        applyStimulus(0, $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                      $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
    end
    drainIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
